// File: rtl/vis_pkg.sv
// Shared constants and types for the spectrum bar display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vis_pkg;

    localparam int NUM_BINS  = 16;
    localparam int IN_W      = 24;
    localparam int H_W       = 11;
    localparam int DISPLAY_H = 480;
    localparam int FS_SHIFT  = 14;
    localparam int DECAY     = 4;
    localparam int IDX_W     = $clog2(NUM_BINS);

    typedef logic [H_W-1:0]         height_t;
    typedef logic [IDX_W-1:0]       bin_idx_t;
    typedef logic signed [IN_W-1:0] mag_t;

    typedef enum logic [1:0] {IDLE, SCALE, DRAIN} upd_state_t;

    // One bin issued to the scale unit.
    typedef struct packed {
        bin_idx_t idx;
        mag_t     mag;
    } scale_req_t;

    // Scaled height for one bin, one cycle after issue.
    typedef struct packed {
        bin_idx_t idx;
        height_t  h;
    } scale_res_t;

    localparam height_t DISPLAY_H_T = height_t'(DISPLAY_H);
    localparam height_t DECAY_T     = height_t'(DECAY);

endpackage

// File: rtl/bar_scale.sv
// Converts one signed bin magnitude into a bar height (clamp, saturate, scale).
// Latency: 1 cycle, one bin accepted per cycle.
// Backpressure: none; the sequencer issues at most one bin per cycle.
//
// Ports:
//   clk, rst        pixel clock, async active-high reset
//   req_vld, req    bin index + magnitude to scale
//   res_vld, res    bin index + height, registered
module bar_scale
    import vis_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_vld,
    input  scale_req_t req,
    output logic       res_vld,
    output scale_res_t res
);

    localparam int PROD_W = FS_SHIFT + H_W;

    logic [FS_SHIFT-1:0] m;
    logic                is_neg;
    logic                is_full;
    height_t             h;

    always_comb begin
        m       = req.mag[FS_SHIFT-1:0];
        is_neg  = req.mag[IN_W-1];
        // Any set bit between the sign and the fraction means >= full scale.
        is_full = |req.mag[IN_W-2:FS_SHIFT];
        if (is_neg) begin
            h = '0;
        end else if (is_full) begin
            h = DISPLAY_H_T;
        end else begin
            h = height_t'((PROD_W'(m) * PROD_W'(DISPLAY_H)) >> FS_SHIFT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_vld <= 1'b0;
            res     <= '0;
        end else begin
            res_vld <= req_vld;
            res     <= '{idx: req.idx, h: h};
        end
    end

endmodule

// File: rtl/bar_update_ctrl.sv
// Captures FFT bins on done, sweeps one scale unit over all bins each frame with peak-fall smoothing.
// Latency: sweep of NUM_BINS+1 busy cycles after frame_start; bar_top is 1 cycle after rd_idx.
// Backpressure: none; done/frame_start arriving while busy are dropped and flagged (sticky).
//
// Ports:
//   clk, rst        pixel clock, async active-high reset
//   done, f_flat    capture strobe and packed bin magnitudes
//   frame_start     start of vertical blank, launches a sweep
//   rd_idx, bar_top pixel-path read port (DISPLAY_H - disp[rd_idx], registered)
//   busy            sweep in progress
//   missed_done     sticky: done while busy
//   overrun         sticky: frame_start while busy
module bar_update_ctrl
    import vis_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done,
    input  logic [NUM_BINS*IN_W-1:0] f_flat,
    input  logic                     frame_start,
    input  bin_idx_t                 rd_idx,
    output height_t                  bar_top,
    output logic                     busy,
    output logic                     missed_done,
    output logic                     overrun
);

    upd_state_t state, state_nxt;
    bin_idx_t   idx, idx_nxt;
    logic       start;
    logic       capture;
    logic       pending;
    logic       use_new;

    mag_t       cap  [NUM_BINS];
    height_t    tgt  [NUM_BINS];
    height_t    disp [NUM_BINS];

    scale_req_t req;
    logic       res_vld;
    scale_res_t res;

    height_t    cur_tgt;
    height_t    cur_disp;
    height_t    fallen;
    height_t    new_disp;

    assign busy    = (state != IDLE);
    assign capture = done && !busy;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = SCALE;
                    idx_nxt   = '0;
                    start     = 1'b1;
                end
            end
            SCALE: begin
                idx_nxt = idx + 1'b1;
                if (idx == bin_idx_t'(NUM_BINS-1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // A capture in the same cycle as the sweep start is consumed by that sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= 1'b0;
            use_new     <= 1'b0;
            missed_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (start) begin
                pending <= 1'b0;
                use_new <= pending || capture;
            end else if (capture) begin
                pending <= 1'b1;
            end
            if (done && busy)        missed_done <= 1'b1;
            if (frame_start && busy) overrun     <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BINS; i++) cap[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_BINS; i++) cap[i] <= f_flat[i*IN_W +: IN_W];
        end
    end

    assign req = '{idx: idx, mag: cap[idx]};

    bar_scale u_scale (
        .clk     (clk),
        .rst     (rst),
        .req_vld (state == SCALE),
        .req     (req),
        .res_vld (res_vld),
        .res     (res)
    );

    // Smoothing: rise instantly, fall by at most DECAY rows per frame.
    // Stale sweeps reuse the retained target so bars keep falling.
    always_comb begin
        cur_tgt  = use_new ? res.h : tgt[res.idx];
        cur_disp = disp[res.idx];
        fallen   = (cur_disp > DECAY_T) ? height_t'(cur_disp - DECAY_T) : '0;
        if (cur_tgt >= cur_disp) begin
            new_disp = cur_tgt;
        end else if (fallen > cur_tgt) begin
            new_disp = fallen;
        end else begin
            new_disp = cur_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                tgt[i]  <= '0;
                disp[i] <= '0;
            end
        end else if (res_vld) begin
            tgt[res.idx]  <= cur_tgt;
            disp[res.idx] <= new_disp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_top <= DISPLAY_H_T;
        end else begin
            bar_top <= DISPLAY_H_T - disp[rd_idx];
        end
    end

endmodule

// File: tb/tb_bar_update_ctrl.sv
// Self-checking bench for bar_update_ctrl against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bar_update_ctrl;
    import vis_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     done = 1'b0;
    logic                     frame_start = 1'b0;
    logic [NUM_BINS*IN_W-1:0] f_flat = '0;
    bin_idx_t                 rd_idx = '0;
    height_t                  bar_top;
    logic                     busy;
    logic                     missed_done;
    logic                     overrun;

    int checks = 0;
    int errors = 0;

    int stim   [NUM_BINS];
    int cap_m  [NUM_BINS];
    int tgt_m  [NUM_BINS];
    int disp_m [NUM_BINS];
    bit pending_m, missed_m, overrun_m;

    always #5 clk = ~clk;

    bar_update_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .f_flat      (f_flat),
        .frame_start (frame_start),
        .rd_idx      (rd_idx),
        .bar_top     (bar_top),
        .busy        (busy),
        .missed_done (missed_done),
        .overrun     (overrun)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int scale_ref(input int v);
        if (v < 0) return 0;
        if (v >= (1 << FS_SHIFT)) return DISPLAY_H;
        return (v * DISPLAY_H) / (1 << FS_SHIFT);
    endfunction

    function automatic int rand_mag();
        case ($urandom_range(0, 5))
            0:       return -int'($urandom_range(1, 8388608));
            1:       return int'($urandom_range(0, 16383));
            2:       return 16384;
            3:       return int'($urandom_range(16385, 8388607));
            4:       return 0;
            default: return 8192;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_BINS; i++) begin
            cap_m[i] = 0; tgt_m[i] = 0; disp_m[i] = 0;
        end
        pending_m = 0; missed_m = 0; overrun_m = 0;
    endtask

    task automatic model_capture();
        for (int i = 0; i < NUM_BINS; i++) cap_m[i] = stim[i];
        pending_m = 1;
    endtask

    // One whole frame: fresh targets only if a capture was pending.
    task automatic model_sweep();
        bit use_new;
        use_new   = pending_m;
        pending_m = 0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (use_new) tgt_m[i] = scale_ref(cap_m[i]);
            if (tgt_m[i] >= disp_m[i]) disp_m[i] = tgt_m[i];
            else if (disp_m[i] - DECAY > tgt_m[i]) disp_m[i] = disp_m[i] - DECAY;
            else disp_m[i] = tgt_m[i];
        end
    endtask

    task automatic drive_flat();
        for (int i = 0; i < NUM_BINS; i++) f_flat[i*IN_W +: IN_W] = stim[i][IN_W-1:0];
    endtask

    task automatic rand_stim();
        for (int i = 0; i < NUM_BINS; i++) stim[i] = rand_mag();
    endtask

    task automatic zero_stim();
        for (int i = 0; i < NUM_BINS; i++) stim[i] = 0;
    endtask

    task automatic do_done();
        drive_flat();
        done = 1'b1;
        model_capture();
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic read_bar(input int i, output int v);
        rd_idx = bin_idx_t'(i);
        @(negedge clk);
        v = int'(bar_top);
    endtask

    task automatic check_bars();
        int v;
        for (int i = 0; i < NUM_BINS; i++) begin
            read_bar(i, v);
            chk($sformatf("bar_top[%0d]", i), v, DISPLAY_H - disp_m[i]);
        end
    endtask

    task automatic check_flags();
        chk("busy_idle", int'(busy), 0);
        chk("missed_done", int'(missed_done), int'(missed_m));
        chk("overrun", int'(overrun), int'(overrun_m));
    endtask

    // Launch a sweep at cycle T; optional events at T+done_at / T+fs_at / T+rst_at.
    task automatic run_sweep(input int done_at, input int fs_at, input int rst_at, input bit coinc);
        int n;
        int cyc;
        if (coinc) begin
            drive_flat();
            done = 1'b1;
            model_capture();
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        done        = 1'b0;
        model_sweep();
        n   = 0;
        cyc = 1;
        while (busy && n < 40) begin
            if (cyc == done_at) begin
                for (int i = 0; i < NUM_BINS; i++) stim[i] = 16384;
                drive_flat();
                done     = 1'b1;
                missed_m = 1;
            end
            if (cyc == fs_at) begin
                frame_start = 1'b1;
                overrun_m   = 1;
            end
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_async_busy", int'(busy), 0);
                chk("rst_async_missed", int'(missed_done), 0);
                chk("rst_async_overrun", int'(overrun), 0);
                chk("rst_async_bar_top", int'(bar_top), DISPLAY_H);
                model_reset();
            end
            n++;
            @(negedge clk);
            done        = 1'b0;
            frame_start = 1'b0;
            rst         = 1'b0;
            cyc++;
        end
        if (rst_at < 0) chk("busy_len", n, NUM_BINS + 1);
        if (fs_at >= 0) begin
            repeat (3) begin
                @(negedge clk);
                chk("no_second_sweep", int'(busy), 0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        bit coinc;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_missed", int'(missed_done), 0);
        chk("reset_overrun", int'(overrun), 0);
        chk("reset_bar_top", int'(bar_top), DISPLAY_H);
        rst = 1'b0;
        @(negedge clk);
        check_bars();

        // Single bin at half scale.
        zero_stim();
        stim[3] = 8192;
        do_done();
        run_sweep(-1, -1, -1, 0);
        check_flags();
        check_bars();
        read_bar(3, v);
        chk("one_bin3", v, 240);

        // Clamp and saturation boundaries.
        zero_stim();
        stim[0] = -5; stim[1] = 16383; stim[2] = 16384; stim[3] = 32'h7FFFFF;
        do_done();
        run_sweep(-1, -1, -1, 0);
        check_bars();
        read_bar(0, v); chk("clamp_neg", v, 480);
        read_bar(1, v); chk("clamp_16383", v, 1);
        read_bar(2, v); chk("clamp_16384", v, 0);
        read_bar(3, v); chk("clamp_max", v, 0);

        // Decay: bin 0 at 240, then target 0 for three frames.
        zero_stim();
        stim[0] = 8192;
        do_done();
        run_sweep(-1, -1, -1, 0);
        read_bar(0, v); chk("decay_start", v, 240);
        stim[0] = 0;
        do_done();
        for (int k = 0; k < 3; k++) begin
            run_sweep(-1, -1, -1, 0);
            read_bar(0, v);
            chk($sformatf("decay_frame%0d", k), v, 244 + 4 * k);
        end
        check_bars();

        // done during a sweep is dropped; next sweep runs on stale targets.
        run_sweep(5, -1, -1, 0);
        check_flags();
        run_sweep(-1, -1, -1, 0);
        check_bars();

        // frame_start during a sweep.
        run_sweep(-1, 8, -1, 0);
        check_flags();
        check_bars();

        // done coincident with frame_start while idle.
        rand_stim();
        run_sweep(-1, -1, -1, 1);
        check_bars();

        // Reset in the middle of a sweep.
        rand_stim();
        do_done();
        run_sweep(-1, -1, 6, 0);
        check_flags();
        check_bars();

        // Randomized frames, including captures on the cycle busy falls.
        repeat (20) begin
            coinc = 0;
            if ($urandom_range(0, 3) != 0) begin
                rand_stim();
                if ($urandom_range(0, 1) == 1) coinc = 1;
                else do_done();
            end
            run_sweep(-1, -1, -1, coinc);
            if ($urandom_range(0, 1) == 1) begin
                rand_stim();
                do_done();
            end
            check_flags();
            check_bars();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bar_update_ctrl.md
# bar_update_ctrl

Frame-synchronous controller that sits between the FFT magnitude outputs and the VGA pixel datapath. It captures all bin magnitudes on the FFT `done` strobe. At each vertical-blank start, it sequences one shared scale unit across every bin, converting magnitudes to bar heights with peak-fall smoothing. The pixel path reads the result through a small registered read port, so it no longer needs 16 parallel 48-bit multipliers.

## Interface
- `NUM_BINS`, 16: number of spectrum bins; must be a power of two.
- `IN_W`, 24: signed magnitude width.
- `H_W`, 11: height/row width, matching the VGA counters.
- `DISPLAY_H`, 480: visible rows.
- `FS_SHIFT`, 14: full scale is `2**FS_SHIFT`.
- `DECAY`, 4: maximum bar fall per frame, in rows.

Ports:
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `done`, in, 1: one-cycle strobe; `f_flat` is valid in this cycle.
- `f_flat`, in, `NUM_BINS*IN_W`: bin `i` is at bits `[i*IN_W +: IN_W]`.
- `frame_start`, in, 1: one-cycle pulse at the first vblank line.
- `rd_idx`, in, `log2(NUM_BINS)`: bin selected by the pixel path.
- `bar_top`, out, `H_W`: `DISPLAY_H - disp[rd_idx]`, registered.
- `busy`, out, 1: a scale sweep is in progress.
- `missed_done`, out, 1: sticky; `done` arrived while `busy`.
- `overrun`, out, 1: sticky; `frame_start` arrived while `busy`.

## Operation
- **Capture**
  - `done` with `busy` low: all bins are copied into `cap[]` and `pending` is set.
  - `done` with `busy` high: data is dropped, `missed_done` is set, and `pending` is unchanged.
- **FSM states:** IDLE, SCALE, DRAIN.
- **IDLE → SCALE** on `frame_start`.
  - Set `busy`, `idx <= 0`.
  - If `pending`, clear it and latch `use_new = 1`; otherwise `use_new = 0`.
- **SCALE:** each cycle, issue `idx` to scale stage 1, then `idx++`. At `idx == NUM_BINS-1`, go to DRAIN.
- **DRAIN:** one cycle to retire the last bin, then IDLE with `busy` low.
- **Stage 1 (scale)**
  - Computed only when `use_new`: neg → 0; `>= 2**FS_SHIFT` → `DISPLAY_H`; else `(m * DISPLAY_H) >> FS_SHIFT`.
  - `m` is the low `FS_SHIFT` bits; the product is `FS_SHIFT+H_W` bits and unsigned.
  - Result is registered into `tgt[idx]`.
- **Stage 2 (smooth), one cycle later, every sweep**
  - If `tgt >= disp`: `disp <= tgt`.
  - Else: `disp <= max(disp - DECAY, tgt)`, saturating at 0.
- **Stale data:** with `use_new = 0`, `tgt[]` is retained, so bars keep falling toward the last target.
- **Overrun:** `frame_start` while `busy` is ignored and sets `overrun`.
- **Read port:** `bar_top <= DISPLAY_H - disp[rd_idx]` every cycle, independent of `busy`. Bins already updated in the current sweep show new values.
- **Reset values:**
  - State IDLE, `cap`/`tgt`/`disp` = 0, `pending` = 0.
  - `busy`, `missed_done`, `overrun` = 0.
  - `bar_top` = `DISPLAY_H`.
- **Clearing sticky flags:** reset is the only way.
- **Reset mid-sweep:** returns to the reset values immediately; no partial write survives.

## Timing
- Sweep length: `frame_start` at cycle T.
  - `busy` is high from T+1 to T+NUM_BINS+1 inclusive (17 cycles at 16 bins).
  - Bin `i`'s `disp` updates at T+i+2.
- `bar_top` latency is 1 cycle from `rd_idx`.
- Coincident events:
  - `done` and `frame_start` in the same cycle while in IDLE: the capture lands and the sweep uses it (`use_new = 1`).
  - `done` in the same cycle `busy` falls: treated as not busy, so it is captured.
- The sweep finishes well inside vblank (45 lines × 800 cycles).

## Structure
- Package `vis_pkg`:
  - constants `NUM_BINS`, `IN_W`, `H_W`, `DISPLAY_H`, `FS_SHIFT`;
  - typedef `height_t` (`H_W` bits);
  - enum `upd_state_t` {IDLE, SCALE, DRAIN}.
- Sub-module `bar_scale`: clamp, saturate, multiply and register one bin, 1-cycle latency. It is instantiated once.

## Test plan
- Reset and sweep with one bin set:
  - Stimulus: `done` with bin 3 = 8192, others 0, then `frame_start`.
  - Response: after `busy` falls, `rd_idx = 3` gives `bar_top = 240`; other bins give 480; `busy` is high for exactly 17 cycles.
- Clamping:
  - Stimulus: bins = −5, 16383, 16384, 0x7FFFFF.
  - Response: heights 0, 479, 480, 480, so `bar_top` = 480, 1, 0, 0.
- Decay:
  - Stimulus: bin 0 at 240, then `done` with bin 0 = 0, followed by 3 frames.
  - Response: `bar_top` for bin 0 reads 244, 248, 252.
  - With no new `done`, the decay continues toward the retained target.
- `done` during sweep:
  - Stimulus: `done` at T+5.
  - Response: `cap` unchanged, `missed_done = 1`, and the next sweep has `use_new = 0`.
- `frame_start` during sweep:
  - Stimulus: `frame_start` at T+8.
  - Response: `overrun = 1`, the sweep still ends at T+17, and no second sweep starts.
- Reset mid-sweep:
  - Stimulus: `rst` asserted at T+6.
  - Response: `busy`, flags and `disp` clear asynchronously, and `bar_top = 480` on the next clock.
